// File: rtl/chord_pkg.sv
// Shared definitions for the diatonic chord suggestor: scale tables, quality codes,
// FSM states and pitch-class arithmetic helpers.
package chord_pkg;

    localparam logic MODE_MAJOR = 1'b0;
    localparam logic MODE_MINOR = 1'b1;

    localparam logic [3:0] INVALID_TONE = 4'hF;

    localparam logic [3:0] PC_C  = 4'd0;
    localparam logic [3:0] PC_CS = 4'd1;
    localparam logic [3:0] PC_D  = 4'd2;
    localparam logic [3:0] PC_DS = 4'd3;
    localparam logic [3:0] PC_E  = 4'd4;
    localparam logic [3:0] PC_F  = 4'd5;
    localparam logic [3:0] PC_FS = 4'd6;
    localparam logic [3:0] PC_G  = 4'd7;
    localparam logic [3:0] PC_GS = 4'd8;
    localparam logic [3:0] PC_A  = 4'd9;
    localparam logic [3:0] PC_AS = 4'd10;
    localparam logic [3:0] PC_B  = 4'd11;

    // Semitone offset of each scale degree from the tonic; degree 0 in the low nibble.
    localparam logic [6:0][3:0] MAJOR_TBL = {4'd11, 4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0};
    localparam logic [6:0][3:0] MINOR_TBL = {4'd10, 4'd8, 4'd7, 4'd5, 4'd3, 4'd2, 4'd0};

    typedef enum logic [1:0] {
        Q_MAJ = 2'd0,
        Q_MIN = 2'd1,
        Q_DIM = 2'd2,
        Q_AUG = 2'd3
    } quality_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEGREE,
        S_BUILD,
        S_DONE
    } state_t;

    function automatic logic [3:0] scale_offset(input logic mode, input logic [2:0] deg);
        if (deg == 3'd7) return 4'd0;
        return (mode == MODE_MINOR) ? MINOR_TBL[deg] : MAJOR_TBL[deg];
    endfunction

    function automatic logic [3:0] pc_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 5'd12) ? 4'(s - 5'd12) : s[3:0];
    endfunction

    // (a - b) mod 12 without underflow; both operands expected in 0..11.
    function automatic logic [3:0] pc_sub(input logic [3:0] a, input logic [3:0] b);
        return pc_add(a, 4'd12 - b);
    endfunction

endpackage

// File: rtl/chord_tone_builder.sv
// Combinational stacked-thirds chord builder: tonic, mode and root degree in,
// chord tones (root first) and triad quality out.
module chord_tone_builder
    import chord_pkg::*;
#(
    parameter int NOTES_PER_CHORD = 4
) (
    input  logic [3:0]                       key,
    input  logic                             mode,
    input  logic [2:0]                       root_deg,
    output logic [NOTES_PER_CHORD-1:0][3:0]  tones,
    output quality_t                         quality
);

    for (genvar j = 0; j < NOTES_PER_CHORD; j++) begin : g_tone
        localparam logic [3:0] STEP = 4'((2 * j) % 7);
        logic [3:0] deg_sum;
        logic [2:0] deg;
        assign deg_sum  = {1'b0, root_deg} + STEP;
        assign deg      = (deg_sum >= 4'd7) ? 3'(deg_sum - 4'd7) : deg_sum[2:0];
        assign tones[j] = pc_add(key, scale_offset(mode, deg));
    end

    logic [3:0] third, fifth;
    assign third = pc_sub(tones[1], tones[0]);
    assign fifth = pc_sub(tones[2], tones[0]);

    always_comb begin
        quality = Q_MAJ;
        if (third == 4'd3)
            quality = (fifth == 4'd6) ? Q_DIM : Q_MIN;
        else if (fifth == 4'd8)
            quality = Q_AUG;
    end

endmodule

// File: rtl/diatonic_chord_suggestor.sv
// Suggests diatonic chords containing a detected note: locates the note's scale degree,
// then builds one candidate chord per cycle and holds the result for the voicing stage.
module diatonic_chord_suggestor
    import chord_pkg::*;
#(
    parameter int NOTES_PER_CHORD = 4,
    parameter int NUM_CANDIDATES  = 4,
    parameter bit ALLOW_DIM       = 1'b1
) (
    input  logic                                        clock,
    input  logic                                        reset_n,
    input  logic                                        recalculate,
    input  logic [3:0]                                  key,
    input  logic                                        mode,
    input  logic [3:0]                                  note,
    output logic                                        ready,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [NUM_CANDIDATES*NOTES_PER_CHORD*4-1:0] chords,
    output logic [2*NUM_CANDIDATES-1:0]                 quality,
    output logic [NUM_CANDIDATES-1:0]                   candidate_valid,
    output logic                                        out_of_key
);

    localparam int W  = NOTES_PER_CHORD * 4;
    localparam int KW = (NUM_CANDIDATES > 1) ? $clog2(NUM_CANDIDATES) : 1;

    if (NUM_CANDIDATES < 1 || NUM_CANDIDATES > NOTES_PER_CHORD) begin : g_bad_cand
        $error("NUM_CANDIDATES must be in 1..NOTES_PER_CHORD");
    end
    if (NOTES_PER_CHORD < 3 || NOTES_PER_CHORD > 7) begin : g_bad_notes
        $error("NOTES_PER_CHORD must be in 3..7");
    end

    state_t state, state_nxt;

    logic [3:0]    key_q, note_q;
    logic          mode_q;
    logic [2:0]    deg_q;
    logic [KW-1:0] k_q;

    logic [NUM_CANDIDATES-1:0][W-1:0] chords_q;
    logic [NUM_CANDIDATES-1:0][1:0]   quality_q;
    logic [NUM_CANDIDATES-1:0]        cvalid_q;
    logic                             ook_q;

    // Degree search on the captured inputs.
    logic [3:0] offset;
    logic       deg_found, deg_ok;
    logic [2:0] deg_idx;

    assign offset = pc_sub(note_q, key_q);

    always_comb begin
        deg_found = 1'b0;
        deg_idx   = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (scale_offset(mode_q, 3'(i)) == offset) begin
                deg_found = 1'b1;
                deg_idx   = 3'(i);
            end
        end
    end

    assign deg_ok = deg_found && (key_q < 4'd12) && (note_q < 4'd12);

    // Candidate k takes root degree (d - 2k) mod 7: root, then the chords where the note is 3rd, 5th, 7th.
    logic [3:0] rsum;
    logic [2:0] root_deg;
    assign rsum     = 4'(deg_q) + 4'd7 - 4'({k_q, 1'b0});
    assign root_deg = (rsum >= 4'd7) ? 3'(rsum - 4'd7) : rsum[2:0];

    logic [NOTES_PER_CHORD-1:0][3:0] tones;
    quality_t                        bq;

    chord_tone_builder #(
        .NOTES_PER_CHORD(NOTES_PER_CHORD)
    ) u_builder (
        .key     (key_q),
        .mode    (mode_q),
        .root_deg(root_deg),
        .tones   (tones),
        .quality (bq)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (recalculate) state_nxt = S_DEGREE;
            S_DEGREE: state_nxt = deg_ok ? S_BUILD : S_DONE;
            S_BUILD:  if (k_q == KW'(NUM_CANDIDATES - 1)) state_nxt = S_DONE;
            S_DONE:   if (out_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key_q     <= '0;
            note_q    <= '0;
            mode_q    <= 1'b0;
            deg_q     <= '0;
            k_q       <= '0;
            chords_q  <= '1;
            quality_q <= '0;
            cvalid_q  <= '0;
            ook_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (recalculate) begin
                    key_q     <= key;
                    note_q    <= note;
                    mode_q    <= mode;
                    chords_q  <= '1;
                    quality_q <= '0;
                    cvalid_q  <= '0;
                    ook_q     <= 1'b0;
                end
                S_DEGREE: begin
                    deg_q <= deg_idx;
                    k_q   <= '0;
                    if (!deg_ok) ook_q <= 1'b1;
                end
                S_BUILD: begin
                    // A filtered diminished slot keeps its cleared INVALID_TONE contents.
                    if (!(bq == Q_DIM && !ALLOW_DIM)) begin
                        chords_q[k_q]  <= tones;
                        quality_q[k_q] <= bq;
                        cvalid_q[k_q]  <= 1'b1;
                    end
                    k_q <= k_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ready           = (state == S_IDLE);
    assign out_valid       = (state == S_DONE);
    assign chords          = chords_q;
    assign quality         = quality_q;
    assign candidate_valid = cvalid_q;
    assign out_of_key      = ook_q;

endmodule

// File: tb/tb_diatonic_chord_suggestor.sv
// Directed bench for diatonic_chord_suggestor: default, no-diminished and triad builds,
// scoreboarded against a behavioural chord model.
module tb_diatonic_chord_suggestor;
    import chord_pkg::*;

    logic clock = 1'b0, reset_n = 1'b0, recalculate = 1'b0, mode = 1'b0, out_ready = 1'b0;
    logic [3:0] key = 4'd0, note = 4'd0;

    logic ready, out_valid, ook;
    logic [63:0] chords;
    logic [7:0]  quality;
    logic [3:0]  cv;

    logic ready_n, ov_n, ook_n;
    logic [63:0] chords_n;
    logic [7:0]  q_n;
    logic [3:0]  cv_n;

    logic ready_3, ov_3, ook_3;
    logic [35:0] chords_3;
    logic [5:0]  q_3;
    logic [2:0]  cv_3;

    always #5 clock = ~clock;

    diatonic_chord_suggestor dut (
        .clock(clock), .reset_n(reset_n), .recalculate(recalculate), .key(key), .mode(mode),
        .note(note), .ready(ready), .out_valid(out_valid), .out_ready(out_ready),
        .chords(chords), .quality(quality), .candidate_valid(cv), .out_of_key(ook));

    diatonic_chord_suggestor #(.ALLOW_DIM(1'b0)) dut_nd (
        .clock(clock), .reset_n(reset_n), .recalculate(recalculate), .key(key), .mode(mode),
        .note(note), .ready(ready_n), .out_valid(ov_n), .out_ready(out_ready),
        .chords(chords_n), .quality(q_n), .candidate_valid(cv_n), .out_of_key(ook_n));

    diatonic_chord_suggestor #(.NOTES_PER_CHORD(3), .NUM_CANDIDATES(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .recalculate(recalculate), .key(key), .mode(mode),
        .note(note), .ready(ready_3), .out_valid(ov_3), .out_ready(out_ready),
        .chords(chords_3), .quality(q_3), .candidate_valid(cv_3), .out_of_key(ook_3));

    typedef struct packed {
        logic [63:0] ch;
        logic [7:0]  q;
        logic [3:0]  cv;
        logic        ook;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

    // Reference model for the default 4-note, 4-candidate configuration.
    function automatic exp_t model(input int k, input int m, input int n, input bit allow_dim);
        int maj[7] = '{0, 2, 4, 5, 7, 9, 11};
        int mnr[7] = '{0, 2, 3, 5, 7, 8, 10};
        int sc[7];
        int t[4];
        int off, d, r, third, fifth, qv;
        exp_t e;
        e.ch = '1; e.q = '0; e.cv = '0; e.ook = 1'b0;
        if (k >= 12 || n >= 12) begin e.ook = 1'b1; return e; end
        for (int i = 0; i < 7; i++) sc[i] = (m == 1) ? mnr[i] : maj[i];
        off = (n - k + 12) % 12;
        d = -1;
        for (int i = 0; i < 7; i++) if (sc[i] == off) d = i;
        if (d < 0) begin e.ook = 1'b1; return e; end
        for (int c = 0; c < 4; c++) begin
            r = (d + 7 - 2 * c) % 7;
            for (int j = 0; j < 4; j++) t[j] = (k + sc[(r + 2 * j) % 7]) % 12;
            third = (t[1] - t[0] + 12) % 12;
            fifth = (t[2] - t[0] + 12) % 12;
            if (third == 4) qv = (fifth == 8) ? 3 : 0;
            else            qv = (fifth == 6) ? 2 : 1;
            if (qv == 2 && !allow_dim) continue;
            for (int j = 0; j < 4; j++) e.ch[c*16 + j*4 +: 4] = 4'(t[j]);
            e.q[c*2 +: 2] = 2'(qv);
            e.cv[c] = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one accepted request, waits (bounded) for out_valid and checks it against the scoreboard.
    // Latency counts the accept edge as cycle 1.
    task automatic run_req(input logic [3:0] k, input logic m, input logic [3:0] n,
                           input int exp_lat, input string tag);
        exp_t e;
        int lat;
        sb.push_back(model(int'(k), int'(m), int'(n), 1'b1));
        key = k; mode = m; note = n; recalculate = 1'b1;
        @(posedge clock); #1;
        recalculate = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        e = sb.pop_front();
        chk({tag, ".chords"}, chords, e.ch);
        chk({tag, ".quality"}, 64'(quality), 64'(e.q));
        chk({tag, ".cvalid"}, 64'(cv), 64'(e.cv));
        chk({tag, ".ook"}, 64'(ook), 64'(e.ook));
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
        chk({tag, ".ready"}, 64'(ready), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ready"}, 64'(ready), 64'd1);
        chk({tag, ".ov"}, 64'(out_valid), 64'd0);
        chk({tag, ".chords"}, chords, 64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, ".quality"}, 64'(quality), 64'd0);
        chk({tag, ".cvalid"}, 64'(cv), 64'd0);
        chk({tag, ".ook"}, 64'(ook), 64'd0);
        chk({tag, ".ready_n"}, 64'(ready_n), 64'd1);
        chk({tag, ".chords3"}, 64'(chords_3), 64'h0000_000F_FFFF_FFFF);
        chk({tag, ".ready3"}, 64'(ready_3), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] held_ch;
        logic [7:0]  held_q;
        exp_t        en;
        bit          quiet;
        int          lat_s;

        #12;
        chk_reset_vals("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // C major, E: Em7, Cmaj7, Am7, Fmaj7
        run_req(PC_C, MODE_MAJOR, PC_E, 6, "t1");
        chk("t1.const_chords", chords, 64'h4095_7409_B740_2B74);
        chk("t1.const_quality", 64'(quality), 64'b00_01_00_01);
        chk("t1.const_cvalid", 64'(cv), 64'hF);
        chk("t1.ov3", 64'(ov_3), 64'd1);
        chk("t1.chords3", 64'(chords_3), 64'h4_0974_0B74);
        handoff("t1");

        // D major, C#: leading-tone chord filtered in the no-diminished build
        run_req(PC_D, MODE_MAJOR, PC_CS, 6, "t2");
        en = model(2, 0, 1, 1'b0);
        chk("t2.nd_ov", 64'(ov_n), 64'd1);
        chk("t2.nd_cand0", 64'(chords_n[15:0]), 64'hFFFF);
        chk("t2.nd_cv0", 64'(cv_n[0]), 64'd0);
        chk("t2.nd_cand1", 64'(chords_n[31:16]), 64'h7419);
        chk("t2.nd_q1", 64'(q_n[3:2]), 64'(Q_MAJ));
        chk("t2.nd_chords", chords_n, en.ch);
        chk("t2.nd_quality", 64'(q_n), 64'(en.q));
        chk("t2.nd_cvalid", 64'(cv_n), 64'(en.cv));
        chk("t2.main_q0", 64'(quality[1:0]), 64'(Q_DIM));
        handoff("t2");

        // Out of key, and out-of-range note
        run_req(PC_C, MODE_MAJOR, PC_CS, 2, "t3a");
        chk("t3a.ook3", 64'(ook_3), 64'd1);
        handoff("t3a");
        run_req(PC_C, MODE_MAJOR, 4'd12, 2, "t3b");
        chk("t3b.ook_n", 64'(ook_n), 64'd1);
        handoff("t3b");

        // A minor, C
        run_req(PC_A, MODE_MINOR, PC_C, 6, "t4");
        chk("t4.cand0", 64'(chords[15:0]), 64'hB740);
        chk("t4.q0", 64'(quality[1:0]), 64'(Q_MAJ));
        chk("t4.cand0_3", 64'(chords_3[11:0]), 64'h740);
        handoff("t4");

        // F minor sweep over every pitch class, plus an out-of-range key
        for (int n = 0; n < 12; n++) begin
            en = model(5, 1, n, 1'b1);
            run_req(PC_F, MODE_MINOR, 4'(n), en.ook ? 2 : 6, $sformatf("sweep%0d", n));
            handoff($sformatf("sweep%0d", n));
        end
        run_req(4'd14, MODE_MAJOR, PC_DS, 2, "badkey");
        handoff("badkey");

        // Consumer stall: result must hold and requests must be dropped
        run_req(PC_G, MODE_MAJOR, PC_B, 6, "t5");
        held_ch = chords;
        held_q  = quality;
        for (int i = 0; i < 10; i++) begin
            key = PC_D; note = PC_FS; recalculate = i[0];
            @(posedge clock); #1;
            chk($sformatf("t5.hold_ready%0d", i), 64'(ready), 64'd0);
            chk($sformatf("t5.hold_ov%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("t5.hold_ch%0d", i), chords, held_ch);
            chk($sformatf("t5.hold_q%0d", i), 64'(quality), 64'(held_q));
        end
        recalculate = 1'b0;
        handoff("t5");
        chk("t5.keep_after", chords, held_ch);
        run_req(PC_E, MODE_MINOR, PC_G, 6, "t5b");
        handoff("t5b");

        // Reset during BUILD k=2 aborts the request
        key = PC_C; mode = MODE_MAJOR; note = PC_E; recalculate = 1'b1;
        @(posedge clock); #1;
        recalculate = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("t6.busy", 64'(ready), 64'd0);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6.async");
        @(posedge clock); #1;
        chk_reset_vals("t6.next");
        @(negedge clock);
        reset_n = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(posedge clock); #1;
            if (out_valid || !ready) quiet = 1'b0;
        end
        chk("t6.no_ov", 64'(quiet), 64'd1);
        run_req(PC_C, MODE_MAJOR, PC_E, 6, "t6b");
        handoff("t6b");

        // Back-to-back throughput: request held high, consumer always ready
        out_ready = 1'b1;
        key = PC_C; mode = MODE_MAJOR; note = PC_G; recalculate = 1'b1;
        @(posedge clock); #1;
        lat_s = 1;
        while (!(ready && lat_s > 1) && lat_s < 40) begin @(posedge clock); #1; lat_s++; end
        chk("tput.period", 64'(lat_s), 64'd7);
        recalculate = 1'b0;
        out_ready = 1'b0;
        repeat (8) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
